// File: rtl/multicycle_pkg.sv
// ============================================================================
//  Module   : multicycle_pkg
//  Purpose  : Shared state encoding, opcodes and datapath select codes for the
//             multi-cycle RV32I control unit, alu_control and the datapath.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_SRC_A_PC    = 2'b00;
  localparam logic [1:0] ALU_SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] ALU_SRC_A_RS1   = 2'b10;

  localparam logic [1:0] ALU_SRC_B_RS2    = 2'b00;
  localparam logic [1:0] ALU_SRC_B_IMM    = 2'b01;
  localparam logic [1:0] ALU_SRC_B_CONST4 = 2'b10;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] RESULT_SRC_ALUOUT  = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEMDATA = 2'b01;
  localparam logic [1:0] RESULT_SRC_ALURES  = 2'b10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // Immediate format implied by the major opcode; formats without an
  // immediate fall back to I, which the datapath ignores.
  function automatic logic [2:0] imm_type_of(input logic [6:0] opc);
    logic [2:0] t;
    t = IMM_I;
    case (opc)
      OPC_STORE:           t = IMM_S;
      OPC_BRANCH:          t = IMM_B;
      OPC_LUI, OPC_AUIPC:  t = IMM_U;
      OPC_JAL:             t = IMM_J;
      default:             t = IMM_I;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
//  Module   : mem_wait_timer
//  Purpose  : Counts consecutive cycles a memory state waits for mem_ready and
//             flags expiry when the count reaches MEM_TIMEOUT.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic done,
  output logic expired
);

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      localparam int CW = $clog2(MEM_TIMEOUT + 1);
      localparam logic [CW-1:0] C_LIMIT = CW'(MEM_TIMEOUT);

      logic [CW-1:0] count_q;
      logic [CW-1:0] count_d;
      logic          hit;

      // Expiry needs the limit reached with no completion this cycle; the
      // counter restarts on completion, on leaving a wait state or on expiry
      // (expiry re-enters FETCH, so there is no state change to clear it).
      always_comb begin
        hit     = waiting && !done && (count_q == C_LIMIT);
        count_d = count_q;
        if (!waiting || done || hit) begin
          count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end

      // Wait counter register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign expired = hit;
    end else begin : g_no_timeout
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, waiting, done};
      assign expired       = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
//  Module   : multicycle_control_unit
//  Purpose  : Moore FSM sequencing RV32I R/OP-IMM/LOAD/STORE/BRANCH/JAL over
//             the multi-cycle datapath with a req/ready memory handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter bit ENABLE_JAL  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [2:0] imm_type,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       bus_error
);

  state_e state_q, state_d;
  logic   bus_error_q, bus_error_d;
  logic   waiting;
  logic   expired;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                   (state_q == S_MEM_WRITE);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .waiting (waiting),
    .done    (mem_ready),
    .expired (expired)
  );

  // Next-state selection; an expired memory wait always falls back to FETCH.
  always_comb begin
    state_d     = state_q;
    bus_error_d = expired;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OPC_OP:               state_d = S_EXEC_R;
          OPC_OP_IMM:           state_d = S_EXEC_I;
          OPC_LOAD, OPC_STORE:  state_d = S_MEM_ADDR;
          OPC_BRANCH:           state_d = S_BRANCH;
          OPC_JAL:              state_d = ENABLE_JAL ? S_JAL : S_TRAP;
          default:              state_d = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = (opcode == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready)    state_d = S_MEM_WB;
        else if (expired) state_d = S_FETCH;
      end
      S_MEM_WRITE: begin
        if (mem_ready || expired) state_d = S_FETCH;
      end
      S_JAL:    state_d = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_TRAP: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register plus the registered one-cycle bus_error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Output decode from the registered state; only the handshake completion
  // strobes look at mem_ready, and DECODE/MEM_ADDR look at the held opcode.
  always_comb begin
    pc_write      = 1'b0;
    branch        = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = ALU_SRC_A_PC;
    alu_src_b     = ALU_SRC_B_RS2;
    alu_op        = ALU_OP_ADD;
    result_src    = RESULT_SRC_ALUOUT;
    imm_type      = IMM_I;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    bus_error     = bus_error_q;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = ALU_SRC_A_PC;
        alu_src_b  = ALU_SRC_B_CONST4;
        result_src = RESULT_SRC_ALURES;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = ALU_SRC_A_OLDPC;
        alu_src_b = ALU_SRC_B_IMM;
        imm_type  = imm_type_of(opcode);
      end
      S_EXEC_R: begin
        alu_src_a = ALU_SRC_A_RS1;
        alu_src_b = ALU_SRC_B_RS2;
        alu_op    = ALU_OP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = ALU_SRC_A_RS1;
        alu_src_b = ALU_SRC_B_IMM;
        alu_op    = ALU_OP_FUNCT;
      end
      S_MEM_ADDR: begin
        alu_src_a = ALU_SRC_A_RS1;
        alu_src_b = ALU_SRC_B_IMM;
        imm_type  = (opcode == OPC_STORE) ? IMM_S : IMM_I;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEM_WB: begin
        result_src = RESULT_SRC_MEMDATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = ALU_SRC_A_RS1;
        alu_src_b  = ALU_SRC_B_RS2;
        alu_op     = ALU_OP_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = ALU_SRC_A_OLDPC;
        alu_src_b = ALU_SRC_B_CONST4;
        pc_write  = 1'b1;
        imm_type  = IMM_J;
      end
      S_TRAP: begin
        illegal_instr = 1'b1;
        instr_done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
//  Module   : tb_multicycle_control_unit
//  Purpose  : Randomized self-checking bench; an instruction-level timeline
//             model predicts every output for every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_control_unit;

  localparam int T_A = 4;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] res_src;
    logic [2:0] imm;
    logic       done;
    logic       ill;
    logic       berr;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;

  always #5 clk = ~clk;

  // Instance A: short timeout, JAL enabled.
  logic a_pc_write, a_branch, a_ir_write, a_reg_write, a_mem_req, a_mem_we, a_adr_src;
  logic [1:0] a_src_a, a_src_b, a_alu_op, a_res_src;
  logic [2:0] a_imm;
  logic a_done, a_ill, a_berr;
  // Instance B: timeout disabled, JAL illegal.
  logic b_pc_write, b_branch, b_ir_write, b_reg_write, b_mem_req, b_mem_we, b_adr_src;
  logic [1:0] b_src_a, b_src_b, b_alu_op, b_res_src;
  logic [2:0] b_imm;
  logic b_done, b_ill, b_berr;

  multicycle_control_unit #(.MEM_TIMEOUT(T_A), .ENABLE_JAL(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(a_pc_write), .branch(a_branch), .ir_write(a_ir_write),
    .reg_write(a_reg_write), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .adr_src(a_adr_src), .alu_src_a(a_src_a), .alu_src_b(a_src_b),
    .alu_op(a_alu_op), .result_src(a_res_src), .imm_type(a_imm),
    .instr_done(a_done), .illegal_instr(a_ill), .bus_error(a_berr)
  );

  multicycle_control_unit #(.MEM_TIMEOUT(0), .ENABLE_JAL(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(b_pc_write), .branch(b_branch), .ir_write(b_ir_write),
    .reg_write(b_reg_write), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .adr_src(b_adr_src), .alu_src_a(b_src_a), .alu_src_b(b_src_b),
    .alu_op(b_alu_op), .result_src(b_res_src), .imm_type(b_imm),
    .instr_done(b_done), .illegal_instr(b_ill), .bus_error(b_berr)
  );

  ctl_t out_a, out_b;
  assign out_a = {a_pc_write, a_branch, a_ir_write, a_reg_write, a_mem_req, a_mem_we,
                  a_adr_src, a_src_a, a_src_b, a_alu_op, a_res_src, a_imm,
                  a_done, a_ill, a_berr};
  assign out_b = {b_pc_write, b_branch, b_ir_write, b_reg_write, b_mem_req, b_mem_we,
                  b_adr_src, b_src_a, b_src_b, b_alu_op, b_res_src, b_imm,
                  b_done, b_ill, b_berr};

  int n_checks = 0;
  int n_fail   = 0;

  // Model configuration and state.
  bit use_b        = 1'b0;
  int t_model      = T_A;
  bit jal_en       = 1'b1;
  bit berr_pending = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic ctl_t cur();
    return use_b ? out_b : out_a;
  endfunction

  function automatic ctl_t mask_noimm();
    ctl_t m;
    m = '1;
    m.imm = 3'b000;
    return m;
  endfunction

  // Called at posedge+1 with inputs already set; compares at the negedge.
  task automatic step(input ctl_t e, input ctl_t m, input string tag);
    @(negedge clk);
    check_eq(tag, 32'(cur() & m), 32'(e & m));
    @(posedge clk);
    #1;
  endtask

  task automatic simple(input ctl_t e, input string tag);
    mem_ready = 1'($urandom_range(0, 1));
    step(e, '1, tag);
  endtask

  // Number of not-ready cycles before mem_ready rises; sometimes right at or
  // past the timeout limit.
  function automatic int pick_delay(input int forced);
    int r;
    if (forced >= 0) return forced;
    r = int'($urandom_range(0, 9));
    if (r < 5)  return 0;
    if (r < 7)  return int'($urandom_range(1, 3));
    if (r == 7) return (t_model > 0) ? t_model : 6;
    if (r == 8) return ((t_model > 0) ? t_model : 6) + 1 + int'($urandom_range(0, 2));
    return 1;
  endfunction

  // One handshake phase: kind 0 = fetch, 1 = load read, 2 = store write.
  task automatic mem_wait(input int kind, input int forced, output bit ok);
    int   d, waited;
    bit   fin;
    ctl_t e;
    string tag;
    d = pick_delay(forced);
    waited = 0;
    ok  = 1'b0;
    fin = 1'b0;
    tag = (kind == 0) ? "fetch" : (kind == 1) ? "mem_read" : "mem_write";
    while (!fin) begin
      mem_ready = (waited >= d);
      if (kind == 0) opcode = 7'($urandom);
      e = '0;
      e.mem_req = 1'b1;
      if (kind == 0) begin
        e.src_b   = 2'b10;
        e.res_src = 2'b10;
      end else begin
        e.adr_src = 1'b1;
      end
      if (kind == 2) e.mem_we = 1'b1;
      e.berr = berr_pending;
      berr_pending = 1'b0;
      if (mem_ready) begin
        if (kind == 0) begin
          e.ir_write = 1'b1;
          e.pc_write = 1'b1;
        end
        if (kind == 2) e.done = 1'b1;
      end
      step(e, '1, tag);
      if (mem_ready) begin
        ok  = 1'b1;
        fin = 1'b1;
      end else if (t_model > 0 && waited == t_model) begin
        berr_pending = 1'b1;
        fin = 1'b1;
      end else begin
        waited++;
      end
    end
  endtask

  task automatic fetch_until_ok(input int fd);
    bit ok;
    int f;
    ok = 1'b0;
    f  = fd;
    while (!ok) begin
      mem_wait(0, f, ok);
      f = -1;
    end
  endtask

  task automatic decode(input logic [6:0] opc);
    ctl_t e;
    bit   known;
    opcode    = opc;
    mem_ready = 1'($urandom_range(0, 1));
    e = '0;
    e.src_a = 2'b01;
    e.src_b = 2'b01;
    known = 1'b1;
    case (opc)
      7'b0000011, 7'b0010011: e.imm = 3'd0;
      7'b0100011:             e.imm = 3'd1;
      7'b1100011:             e.imm = 3'd2;
      7'b1101111: begin
        e.imm = 3'd4;
        known = jal_en;
      end
      default: known = 1'b0;
    endcase
    step(e, known ? '1 : mask_noimm(), "decode");
  endtask

  task automatic alu_wb();
    ctl_t e;
    e = '0;
    e.reg_write = 1'b1;
    e.done = 1'b1;
    simple(e, "alu_wb");
  endtask

  task automatic run_instr(input logic [6:0] opc, input int fd_fetch, input int fd_mem);
    ctl_t e;
    bit   ok;
    fetch_until_ok(fd_fetch);
    decode(opc);
    e = '0;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      e.src_a  = 2'b10;
      e.src_b  = (opc == 7'b0010011) ? 2'b01 : 2'b00;
      e.alu_op = 2'b10;
      simple(e, "exec");
      alu_wb();
    end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
      e.src_a = 2'b10;
      e.src_b = 2'b01;
      e.imm   = (opc == 7'b0100011) ? 3'd1 : 3'd0;
      simple(e, "mem_addr");
      if (opc == 7'b0000011) begin
        mem_wait(1, fd_mem, ok);
        if (ok) begin
          e = '0;
          e.res_src   = 2'b01;
          e.reg_write = 1'b1;
          e.done      = 1'b1;
          simple(e, "mem_wb");
        end
      end else begin
        mem_wait(2, fd_mem, ok);
      end
    end else if (opc == 7'b1100011) begin
      e.src_a  = 2'b10;
      e.alu_op = 2'b01;
      e.branch = 1'b1;
      e.done   = 1'b1;
      simple(e, "branch");
    end else if (opc == 7'b1101111 && jal_en) begin
      e.src_a    = 2'b01;
      e.src_b    = 2'b10;
      e.pc_write = 1'b1;
      e.imm      = 3'd4;
      simple(e, "jal");
      alu_wb();
    end else begin
      e.ill  = 1'b1;
      e.done = 1'b1;
      simple(e, "trap");
    end
  endtask

  function automatic logic [6:0] rand_opcode();
    logic [6:0] tbl [8];
    tbl = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1111111, 7'b0000000};
    tbl[7] = 7'($urandom);
    return tbl[$urandom_range(0, 7)];
  endfunction

  task automatic do_reset();
    ctl_t z;
    z = '0;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset", 32'(cur()), 32'(z));
    rst_n = 1'b1;
    berr_pending = 1'b0;
    step(z, '1, "idle");
  endtask

  // Asynchronous reset in the middle of a load's read phase.
  task automatic reset_mid_read();
    ctl_t e, z;
    z = '0;
    fetch_until_ok(0);
    decode(7'b0000011);
    e = '0;
    e.src_a = 2'b10;
    e.src_b = 2'b01;
    simple(e, "mem_addr");
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", 32'(cur()), 32'(z));
    @(posedge clk);
    #1;
    check_eq("rst_hold", 32'(cur()), 32'(z));
    rst_n = 1'b1;
    berr_pending = 1'b0;
    step(z, '1, "idle_after_rst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Instance A: directed cases then random traffic.
    use_b = 1'b0; t_model = T_A; jal_en = 1'b1;
    do_reset();
    run_instr(7'b0110011, 0, 0);
    run_instr(7'b0000011, 0, 3);
    run_instr(7'b0100011, 0, 0);
    run_instr(7'b1100011, 0, 0);
    run_instr(7'b1111111, 0, 0);
    run_instr(7'b1101111, 0, 0);
    run_instr(7'b0010011, T_A + 1, 0);
    run_instr(7'b0110011, T_A, 0);
    run_instr(7'b0000011, 0, T_A + 1);
    run_instr(7'b0100011, 0, T_A + 1);
    run_instr(7'b0100011, 0, T_A);
    run_instr(7'b0000011, 0, T_A);
    for (int i = 0; i < 200; i++) run_instr(rand_opcode(), -1, -1);
    reset_mid_read();
    for (int i = 0; i < 20; i++) run_instr(rand_opcode(), -1, -1);

    // Instance B: timeout disabled, JAL treated as illegal.
    use_b = 1'b1; t_model = 0; jal_en = 1'b0;
    do_reset();
    run_instr(7'b1101111, 0, 0);
    run_instr(7'b0110011, 20, 0);
    run_instr(7'b0100011, 0, 12);
    for (int i = 0; i < 40; i++) run_instr(rand_opcode(), -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
